// File: rtl/segre_sb_port_ctrl.sv
// ---------------------------------------------------------------------------
// segre_sb_port_ctrl
//
// Purpose:
//   Control-only arbiter between the MEM stage, the store buffer and the
//   single data-cache port. Every cycle it decides whether the cache port
//   serves a pipeline load miss or a store-buffer drain. It gates store
//   insertion, forces complete drains on full-buffer, overlap-trouble and
//   fence events, tracks store-buffer occupancy and raises the pipeline
//   stall. No data passes through this block.
//
// Parameters:
//   SB_ENTRIES        store buffer depth (occupancy counter holds 0..SB_ENTRIES)
//
// Ports:
//   clk_i             clock
//   rsn_i             asynchronous active-low reset
//   ld_req_i          MEM stage load valid
//   st_req_i          MEM stage store valid
//   fence_i           request to drain the store buffer completely
//   sb_hit_i          store buffer address hit for the current access
//   sb_full_i         store buffer full (qualified by a store request)
//   sb_trouble_i      store overlaps an entry with incompatible size
//   sb_data_valid_i   store buffer presents a valid flush entry
//   cache_ready_i     cache port accepts a request this cycle
//   cache_rvalid_i    load data returned by the cache
//   sb_req_load_o     forward load to store buffer lookup
//   sb_req_store_o    commit store into the store buffer this cycle
//   sb_flush_chance_o store buffer may pop its oldest entry this cycle
//   cache_req_o       request on the cache port
//   cache_we_o        1 = store drain from buffer, 0 = load miss
//   ld_from_sb_o      load data is supplied by the store buffer
//   stall_o           hold MEM stage and everything upstream
//   fence_done_o      single-cycle pulse when a fence drain completes
// ---------------------------------------------------------------------------
module segre_sb_port_ctrl #(
  parameter int SB_ENTRIES = 2
) (
  input  logic clk_i,
  input  logic rsn_i,
  input  logic ld_req_i,
  input  logic st_req_i,
  input  logic fence_i,
  input  logic sb_hit_i,
  input  logic sb_full_i,
  input  logic sb_trouble_i,
  input  logic sb_data_valid_i,
  input  logic cache_ready_i,
  input  logic cache_rvalid_i,
  output logic sb_req_load_o,
  output logic sb_req_store_o,
  output logic sb_flush_chance_o,
  output logic cache_req_o,
  output logic cache_we_o,
  output logic ld_from_sb_o,
  output logic stall_o,
  output logic fence_done_o
);

  localparam int OCC_W = $clog2(SB_ENTRIES + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(SB_ENTRIES);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             fence_pend_q, fence_pend_d;

  logic occ_empty;
  logic idle_turn;
  logic occ_inc;
  logic occ_dec;

  logic sb_req_load;
  logic sb_req_store;
  logic sb_flush_chance;
  logic cache_req;
  logic cache_we;
  logic ld_from_sb;
  logic stall;
  logic fence_done;

  assign occ_empty = (occ_q == '0);

  // A DRAIN that starts a cycle with an empty buffer hands the cycle straight
  // back to IDLE, so the request that caused the drain is re-evaluated without
  // a bubble.
  assign idle_turn = (state_q == IDLE) || ((state_q == DRAIN) && occ_empty);

  // Next-state and control decode. LOAD and DRAIN are handled first; the IDLE
  // decision block then runs whenever idle_turn is set, on top of whatever the
  // DRAIN-exit path already decided.
  always_comb begin
    state_d         = state_q;
    fence_pend_d    = fence_pend_q;
    occ_inc         = 1'b0;
    occ_dec         = 1'b0;
    sb_req_load     = 1'b0;
    sb_req_store    = 1'b0;
    sb_flush_chance = 1'b0;
    cache_req       = 1'b0;
    cache_we        = 1'b0;
    ld_from_sb      = 1'b0;
    stall           = 1'b0;
    fence_done      = 1'b0;

    case (state_q)
      LOAD: begin
        // The stall drops in the very cycle the data returns.
        if (cache_rvalid_i) begin
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end

      DRAIN: begin
        if (!occ_empty) begin
          stall           = 1'b1;
          sb_flush_chance = cache_ready_i;
          if (cache_ready_i && sb_data_valid_i) begin
            cache_req = 1'b1;
            cache_we  = 1'b1;
            occ_dec   = 1'b1;
          end
        end else begin
          state_d      = IDLE;
          fence_done   = fence_pend_q;
          fence_pend_d = 1'b0;
        end
      end

      default: begin
      end
    endcase

    if (idle_turn) begin
      if (fence_i && !occ_empty) begin
        // Fence with stores still buffered: drain everything first.
        stall        = 1'b1;
        fence_pend_d = 1'b1;
        state_d      = DRAIN;
      end else begin
        // A fence on an empty buffer completes at once and does not consume
        // the cycle, so a load or store presented alongside is still served.
        if (fence_i) begin
          fence_done = 1'b1;
        end

        if (ld_req_i) begin
          sb_req_load = 1'b1;
          if (sb_hit_i) begin
            ld_from_sb = 1'b1;
          end else begin
            stall = 1'b1;
            if (cache_ready_i) begin
              cache_req = 1'b1;
              cache_we  = 1'b0;
              state_d   = LOAD;
            end
          end
        end else if (st_req_i) begin
          if ((sb_full_i && !sb_hit_i) || sb_trouble_i) begin
            stall   = 1'b1;
            state_d = DRAIN;
          end else begin
            // A hitting store merges into its entry and does not grow the buffer.
            sb_req_store = 1'b1;
            occ_inc      = !sb_hit_i;
          end
        end

        // Opportunistic drain uses the port only when no load competes for it.
        if (!ld_req_i && !stall && !occ_empty && cache_ready_i) begin
          sb_flush_chance = 1'b1;
          if (sb_data_valid_i) begin
            cache_req = 1'b1;
            cache_we  = 1'b1;
            occ_dec   = 1'b1;
          end
        end
      end
    end

    // Simultaneous insert and drain cancel out; the guards keep the counter
    // inside 0..SB_ENTRIES even if an upstream block misbehaves.
    occ_d = occ_q;
    if (occ_inc && !occ_dec && (occ_q != OCC_MAX)) begin
      occ_d = occ_q + OCC_ONE;
    end else if (occ_dec && !occ_inc && !occ_empty) begin
      occ_d = occ_q - OCC_ONE;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q      <= IDLE;
      occ_q        <= '0;
      fence_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q        <= occ_d;
      fence_pend_q <= fence_pend_d;
    end
  end

  // All outputs are forced low while reset is held.
  assign sb_req_load_o     = rsn_i & sb_req_load;
  assign sb_req_store_o    = rsn_i & sb_req_store;
  assign sb_flush_chance_o = rsn_i & sb_flush_chance;
  assign cache_req_o       = rsn_i & cache_req;
  assign cache_we_o        = rsn_i & cache_req & cache_we;
  assign ld_from_sb_o      = rsn_i & ld_from_sb;
  assign stall_o           = rsn_i & stall;
  assign fence_done_o      = rsn_i & fence_done;

  // Occupancy must never be pushed past full or popped below empty.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rsn_i)
    !(occ_inc && !occ_dec && (occ_q == OCC_MAX)));

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rsn_i)
    !(occ_dec && !occ_inc && occ_empty));

endmodule
